// File: rtl/arb_sched_ctrl_pkg.sv
// Shared types and default sizes for the burst-aware round-robin output scheduler.
package arb_sched_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } t_arb_sched_state;

  localparam int unsigned NUM_CLIENTS_DEF = 4;
  localparam int unsigned DATA_WIDTH_DEF  = 32;
  localparam int unsigned STAT_W_DEF      = 16;

endpackage

// File: rtl/arb_sched_ctrl_if.sv
// Requester/output-link bundle of the scheduler; master = queues + link, slave = scheduler.
interface arb_sched_ctrl_if
  import arb_sched_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS = NUM_CLIENTS_DEF,
  parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int unsigned STAT_W      = STAT_W_DEF
);
  logic [NUM_CLIENTS-1:0]                 req_valid;
  logic [NUM_CLIENTS-1:0][DATA_WIDTH-1:0] req_data;
  logic [NUM_CLIENTS-1:0]                 req_last;
  logic [NUM_CLIENTS-1:0]                 req_ready;
  logic                                   out_valid;
  logic [DATA_WIDTH-1:0]                  out_data;
  logic                                   out_last;
  logic [NUM_CLIENTS-1:0]                 out_grant_id;
  logic                                   out_ready;
  logic                                   busy;
  logic [NUM_CLIENTS-1:0][STAT_W-1:0]     stat_cnt;

  modport master (
    output req_valid, req_data, req_last, out_ready,
    input  req_ready, out_valid, out_data, out_last, out_grant_id, busy, stat_cnt
  );

  modport slave (
    input  req_valid, req_data, req_last, out_ready,
    output req_ready, out_valid, out_data, out_last, out_grant_id, busy, stat_cnt
  );
endinterface

// File: rtl/arb_sched_ctrl_rr_pick.sv
// Rotating-priority find-first: first set request strictly after ptr_i, wrapping around.
module rr_pick #(
  parameter  int unsigned N  = 4,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_c_o,
  output logic          any_c_o
);
  logic          found;
  logic [PW-1:0] idx;

  // Scan N positions starting just after the pointer; first hit wins.
  always_comb begin
    grant_c_o = '0;
    found     = 1'b0;
    idx       = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = PW'((32'(ptr_i) + k) % N);
      if (!found && req_i[idx]) begin
        grant_c_o[idx] = 1'b1;
        found          = 1'b1;
      end
    end
  end

  assign any_c_o = |req_i;
endmodule

// File: rtl/arb_sched_ctrl.sv
// Burst-aware round-robin scheduler sharing one output stage between NUM_CLIENTS requesters.
// Optional per-client accepted-beat counters are built only when ARB_SCHED_STATS_EN is defined.
module arb_sched_ctrl
  import arb_sched_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS = NUM_CLIENTS_DEF,
  parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int unsigned STAT_W      = STAT_W_DEF
) (
  input logic             clk,
  input logic             rst,
  arb_sched_ctrl_if.slave bus
);
  localparam int unsigned PW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  t_arb_sched_state       state_q, state_d;
  logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]          lock_id_q, lock_id_d;
  logic                   out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic                   out_last_q, out_last_d;
  logic [NUM_CLIENTS-1:0] out_grant_q, out_grant_d;
  logic                   busy_q, busy_d;

  logic [NUM_CLIENTS-1:0] pick_grant_c;
  logic                   pick_any_c;
  logic [PW-1:0]          pick_idx_c;
  logic [PW-1:0]          sel_idx_c;
  logic                   can_load_c;
  logic [NUM_CLIENTS-1:0] req_ready_c;
  logic [NUM_CLIENTS-1:0] accept_c;

  rr_pick #(.N(NUM_CLIENTS)) u_rr_pick (
    .req_i     (bus.req_valid),
    .ptr_i     (rr_ptr_q),
    .grant_c_o (pick_grant_c),
    .any_c_o   (pick_any_c)
  );

  // One-hot grant to index for payload selection.
  always_comb begin
    pick_idx_c = '0;
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      if (pick_grant_c[i]) pick_idx_c = PW'(i);
    end
  end

  // Grant, burst lock and output-stage next state; a drain and a load in one cycle overwrite.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    lock_id_d   = lock_id_q;
    out_valid_d = out_valid_q & ~bus.out_ready;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_grant_d = out_grant_q;
    req_ready_c = '0;
    sel_idx_c   = pick_idx_c;
    can_load_c  = ~out_valid_q | bus.out_ready;

    case (state_q)
      IDLE: begin
        if (can_load_c && pick_any_c) req_ready_c = pick_grant_c;
      end
      LOCK: begin
        sel_idx_c = lock_id_q;
        if (can_load_c) req_ready_c[lock_id_q] = 1'b1;
      end
      default: ;
    endcase

    accept_c = bus.req_valid & req_ready_c;

    if (|accept_c) begin
      out_valid_d = 1'b1;
      out_data_d  = bus.req_data[sel_idx_c];
      out_last_d  = bus.req_last[sel_idx_c];
      out_grant_d = req_ready_c;
      if (bus.req_last[sel_idx_c]) begin
        state_d  = IDLE;
        rr_ptr_d = sel_idx_c;
      end else begin
        state_d   = LOCK;
        lock_id_d = sel_idx_c;
      end
    end

    busy_d = (state_d == LOCK) | out_valid_d;
  end

  // State and output register; reset aborts any burst and drops the held beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= PW'(NUM_CLIENTS - 1);
      lock_id_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_grant_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_id_q   <= lock_id_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_grant_q <= out_grant_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.req_ready    = req_ready_c;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_last     = out_last_q;
  assign bus.out_grant_id = out_grant_q;
  assign bus.busy         = busy_q;

`ifdef ARB_SCHED_STATS_EN
  logic [NUM_CLIENTS-1:0][STAT_W-1:0] stat_q, stat_d;

  // Saturating count of accepted beats per client.
  always_comb begin
    stat_d = stat_q;
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      if (accept_c[i] && (stat_q[i] != '1)) stat_d[i] = stat_q[i] + STAT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) stat_q <= '0;
    else     stat_q <= stat_d;
  end

  assign bus.stat_cnt = stat_q;
`else
  assign bus.stat_cnt = '0;
`endif

  // At most one requester is offered the slot.
  always_ff @(posedge clk) begin
    if (!rst) a_rdy_onehot: assert ($onehot0(req_ready_c));
  end

  a_out_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid_q && !bus.out_ready) |=>
      (out_valid_q && $stable(out_data_q) && $stable(out_last_q) && $stable(out_grant_q)));

endmodule
